// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
//
// Groups the control FSM's bus signals: debug controls and the instruction
// byte going in, datapath strobes and display status coming out.
//
//   master : board wrapper / datapath side (drives Run, Step, Inst)
//   slave  : the control FSM (drives every strobe and status signal)
//
// Signals:
//   Run        run back-to-back (level)
//   Step       debounced single-step request (rising edge used)
//   Inst[7:0]  instruction memory output at the current PC
//   IRWrite, PCIncr, PCJump, ALUEn, MemRead, MemWrite, RegWrite,
//   RegDst, MemToReg                  datapath strobes / selects
//   Busy, Phase[2:0], Retire, InstCount[7:0]   status for the display path
// ----------------------------------------------------------------------------
interface multicycle_control_if;
    logic       Run;
    logic       Step;
    logic [7:0] Inst;
    logic       IRWrite;
    logic       PCIncr;
    logic       PCJump;
    logic       ALUEn;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       Busy;
    logic [2:0] Phase;
    logic       Retire;
    logic [7:0] InstCount;

    modport master (
        output Run, Step, Inst,
        input  IRWrite, PCIncr, PCJump, ALUEn, MemRead, MemWrite,
               RegWrite, RegDst, MemToReg, Busy, Phase, Retire, InstCount
    );

    modport slave (
        input  Run, Step, Inst,
        output IRWrite, PCIncr, PCJump, ALUEn, MemRead, MemWrite,
               RegWrite, RegDst, MemToReg, Busy, Phase, Retire, InstCount
    );
endinterface

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle control FSM for the 8-bit microprocessor. Each instruction is
// sequenced through FETCH, DECODE, EXEC, MEM and WB; the datapath strobes
// are Moore outputs decoded from the registered state and latched opcode.
// Run executes instructions back-to-back; a Step rising edge seen while
// IDLE executes exactly one instruction.
//
// Ports:
//   clk    system clock, rising edge
//   Reset  synchronous, active-high reset
//   bus    multicycle_control_if.slave (Run/Step/Inst in, strobes and
//          Busy/Phase/Retire/InstCount out)
//
// Cycle counts: ADD 4 (F D E W), LW 5 (F D E M W), SW 4 (F D E M), J 3 (F D E).
// ----------------------------------------------------------------------------
module multicycle_control (
    input  logic                  clk,
    input  logic                  Reset,
    multicycle_control_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic       step_q, step_d;
    logic [7:0] count_q, count_d;

    logic       step_edge;
    logic       retire;
    logic       ir_write, pc_incr, pc_jump, alu_en;
    logic       mem_read, mem_write, reg_write, reg_dst, mem_to_reg;

    // Only the opcode field is decoded; the operand bits belong to the datapath.
    logic       unused_inst_bits;
    assign unused_inst_bits = ^bus.Inst[5:0];

    assign step_edge = bus.Step & ~step_q;

    // ------------------------------------------------------------------
    // Next-state, opcode latch, step history and retire counter.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        step_d  = bus.Step;
        retire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Run wins over Step; a Step edge only counts while idle.
                if (bus.Run || step_edge) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Opcode latches on the same edge the datapath loads IR.
                op_d    = op_t'(bus.Inst[7:6]);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_J: begin
                        retire  = 1'b1;
                        state_d = bus.Run ? S_FETCH : S_IDLE;
                    end
                    OP_ADD:  state_d = S_WB;
                    default: state_d = S_MEM;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LW) begin
                    state_d = S_WB;
                end else begin
                    retire  = 1'b1;
                    state_d = bus.Run ? S_FETCH : S_IDLE;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = bus.Run ? S_FETCH : S_IDLE;
            end
            default: begin
                // Unused codes 6 and 7 recover to IDLE.
                state_d = S_IDLE;
            end
        endcase

        count_d = count_q + {7'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            step_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore strobe decode from registered state and opcode.
    // ------------------------------------------------------------------
    always_comb begin
        ir_write   = 1'b0;
        pc_incr    = 1'b0;
        pc_jump    = 1'b0;
        alu_en     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_incr  = 1'b1;
            end
            S_EXEC: begin
                pc_jump = (op_q == OP_J);
                alu_en  = (op_q != OP_J);
            end
            S_MEM: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_ADD);
                mem_to_reg = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

    assign bus.IRWrite   = ir_write;
    assign bus.PCIncr    = pc_incr;
    assign bus.PCJump    = pc_jump;
    assign bus.ALUEn     = alu_en;
    assign bus.MemRead   = mem_read;
    assign bus.MemWrite  = mem_write;
    assign bus.RegWrite  = reg_write;
    assign bus.RegDst    = reg_dst;
    assign bus.MemToReg  = mem_to_reg;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Phase     = state_q;
    assign bus.Retire    = retire;
    assign bus.InstCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, i.e. they show the
// state entered on that edge. Strobe vector bit order:
// {IRWrite,PCIncr,PCJump,ALUEn,MemRead,MemWrite,RegWrite,RegDst,MemToReg,
//  Busy,Retire}.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

    logic clk;
    logic Reset;

    multicycle_control_if bus_if ();

    multicycle_control dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    logic [10:0] outs;
    assign outs = {bus_if.IRWrite, bus_if.PCIncr, bus_if.PCJump, bus_if.ALUEn,
                   bus_if.MemRead, bus_if.MemWrite, bus_if.RegWrite,
                   bus_if.RegDst, bus_if.MemToReg, bus_if.Busy, bus_if.Retire};

    localparam logic [10:0] V_F     = 11'b11000000010;
    localparam logic [10:0] V_D     = 11'b00000000010;
    localparam logic [10:0] V_EALU  = 11'b00010000010;
    localparam logic [10:0] V_EJ    = 11'b00100000011;
    localparam logic [10:0] V_MLW   = 11'b00001000010;
    localparam logic [10:0] V_MSW   = 11'b00000100011;
    localparam logic [10:0] V_WADD  = 11'b00000011011;
    localparam logic [10:0] V_WLW   = 11'b00000010111;

    logic [2:0]  exp_ph [16] = '{3'd1, 3'd2, 3'd3, 3'd5,
                                 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                 3'd1, 3'd2, 3'd3, 3'd4,
                                 3'd1, 3'd2, 3'd3};
    logic [10:0] exp_st [16] = '{V_F, V_D, V_EALU, V_WADD,
                                 V_F, V_D, V_EALU, V_MLW, V_WLW,
                                 V_F, V_D, V_EALU, V_MSW,
                                 V_F, V_D, V_EJ};
    logic [7:0]  prog   [4]  = '{8'h1B, 8'h48, 8'h94, 8'hC0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset       = 1'b1;
        bus_if.Run  = 1'b0;
        bus_if.Step = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        bus_if.Run  = 1'b1;
        bus_if.Step = 1'b0;
        bus_if.Inst = 8'h1B;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({outs, bus_if.Phase, bus_if.InstCount} !== 22'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got outs=%b phase=%0d cnt=%0d, want all 0",
                         i, outs, bus_if.Phase, bus_if.InstCount);
            end
        end
        Reset = 1'b0;
        tick();
        tests++;
        if (bus_if.Phase !== 3'd1) begin
            fails++;
            $display("FAIL reset_release_phase: got %0d, want 1", bus_if.Phase);
        end
        bus_if.Run = 1'b0;
    endtask

    task automatic test_run_stream();
        int k;
        apply_reset();
        k = 0;
        bus_if.Inst = prog[0];
        bus_if.Run  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            tests++;
            if (bus_if.Phase !== exp_ph[i] || outs !== exp_st[i]) begin
                fails++;
                $display("FAIL run_stream cycle %0d: got phase=%0d outs=%b, want phase=%0d outs=%b",
                         i, bus_if.Phase, outs, exp_ph[i], exp_st[i]);
            end
            if (exp_ph[i] == 3'd1) begin
                bus_if.Inst = prog[k];
                k++;
            end
        end
        tick();
        tests++;
        if (bus_if.InstCount !== 8'd4) begin
            fails++;
            $display("FAIL run_stream_count: got %0d, want 4", bus_if.InstCount);
        end
        bus_if.Run = 1'b0;
    endtask

    task automatic test_step_single();
        int busy_cnt;
        int ret_cnt;
        apply_reset();
        busy_cnt    = 0;
        ret_cnt     = 0;
        bus_if.Inst = 8'h48;
        bus_if.Step = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) begin
                tests++;
                if (bus_if.Phase !== 3'd1) begin
                    fails++;
                    $display("FAIL step_latency: got phase %0d, want 1", bus_if.Phase);
                end
            end
            if (bus_if.Busy === 1'b1) busy_cnt++;
            if (bus_if.Retire === 1'b1) begin
                ret_cnt++;
                tests++;
                if ({bus_if.Phase, bus_if.MemToReg, bus_if.RegDst} !== {3'd5, 1'b1, 1'b0}) begin
                    fails++;
                    $display("FAIL step_lw_wb: got phase=%0d memtoreg=%b regdst=%b, want 5/1/0",
                             bus_if.Phase, bus_if.MemToReg, bus_if.RegDst);
                end
            end
        end
        tests++;
        if (busy_cnt != 5) begin
            fails++;
            $display("FAIL step_busy_cycles: got %0d, want 5", busy_cnt);
        end
        tests++;
        if (ret_cnt != 1) begin
            fails++;
            $display("FAIL step_retire_count: got %0d, want 1", ret_cnt);
        end
        tests++;
        if (bus_if.InstCount !== 8'd1 || bus_if.Phase !== 3'd0) begin
            fails++;
            $display("FAIL step_final: got cnt=%0d phase=%0d, want 1/0",
                     bus_if.InstCount, bus_if.Phase);
        end
        bus_if.Step = 1'b0;
    endtask

    task automatic test_step_ignored_run_drop();
        logic [2:0] want [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0};
        apply_reset();
        bus_if.Inst = 8'h1B;
        bus_if.Run  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (bus_if.Phase !== want[i]) begin
                fails++;
                $display("FAIL step_ignored_run_drop cycle %0d: got phase %0d, want %0d",
                         i, bus_if.Phase, want[i]);
            end
            case (i)
                0: bus_if.Step = 1'b1;   // edge while busy under Run
                1: bus_if.Step = 1'b0;
                2: bus_if.Run  = 1'b0;   // drop Run in ADD EXEC
                3: bus_if.Step = 1'b1;   // edge coincides with instruction end
                default: ;
            endcase
        end
        tests++;
        if (bus_if.InstCount !== 8'd1) begin
            fails++;
            $display("FAIL run_drop_count: got %0d, want 1", bus_if.InstCount);
        end
        bus_if.Step = 1'b0;
    endtask

    task automatic test_wrap();
        int ret_cnt;
        int bad_phase;
        apply_reset();
        ret_cnt     = 0;
        bad_phase   = 0;
        bus_if.Inst = 8'hC0;
        bus_if.Run  = 1'b1;
        for (int i = 0; i < 768; i++) begin
            tick();
            if (bus_if.Retire === 1'b1) begin
                ret_cnt++;
                if (bus_if.Phase !== 3'd3) bad_phase++;
            end
            if (i == 767) begin
                tests++;
                if (bus_if.InstCount !== 8'hFF) begin
                    fails++;
                    $display("FAIL wrap_pre_count: got %0d, want 255", bus_if.InstCount);
                end
            end
        end
        bus_if.Run = 1'b0;
        tick();
        tests++;
        if (bus_if.InstCount !== 8'h00 || bus_if.Phase !== 3'd0) begin
            fails++;
            $display("FAIL wrap_count: got cnt=%0d phase=%0d, want 0/0",
                     bus_if.InstCount, bus_if.Phase);
        end
        tests++;
        if (ret_cnt != 256) begin
            fails++;
            $display("FAIL wrap_retires: got %0d, want 256", ret_cnt);
        end
        tests++;
        if (bad_phase != 0) begin
            fails++;
            $display("FAIL wrap_retire_phase: got %0d retires outside EXEC, want 0", bad_phase);
        end
    endtask

    task automatic test_reset_mid_sw();
        apply_reset();
        bus_if.Inst = 8'h1B;
        bus_if.Run  = 1'b1;
        for (int i = 0; i < 4; i++) tick();   // ADD: F D E W
        bus_if.Inst = 8'h94;
        for (int i = 0; i < 4; i++) tick();   // SW: F D E M
        tests++;
        if ({bus_if.Phase, bus_if.MemWrite, bus_if.InstCount} !== {3'd4, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL sw_mem_before_reset: got phase=%0d memwrite=%b cnt=%0d, want 4/1/1",
                     bus_if.Phase, bus_if.MemWrite, bus_if.InstCount);
        end
        Reset = 1'b1;
        tick();
        tests++;
        if ({outs, bus_if.Phase, bus_if.InstCount} !== 22'd0) begin
            fails++;
            $display("FAIL reset_mid_sw: got outs=%b phase=%0d cnt=%0d, want all 0",
                     outs, bus_if.Phase, bus_if.InstCount);
        end
        Reset      = 1'b0;
        bus_if.Run = 1'b0;
        tick();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        Reset       = 1'b1;
        bus_if.Run  = 1'b0;
        bus_if.Step = 1'b0;
        bus_if.Inst = 8'h00;
        test_reset();
        test_run_stream();
        test_step_single();
        test_step_ignored_run_drop();
        test_wrap();
        test_reset_mid_sw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
